// File: rtl/sc_io_bus_pkg.sv
// Shared definitions for the sc_io_bus data-side I/O stage: register word
// offsets inside the I/O window, KEY register field positions, and the
// offset decoder used by the read mux and the register write enables.
package sc_io_bus_pkg;

    // Register word offsets within the 256-byte I/O window
    localparam logic [7:0] OFS_SW    = 8'h00;
    localparam logic [7:0] OFS_KEY   = 8'h04;
    localparam logic [7:0] OFS_LED   = 8'h10;
    localparam logic [7:0] OFS_HEX   = 8'h20;
    localparam logic [7:0] OFS_TIMER = 8'h30;

    // KEY register layout: sticky press flags low, live level from bit 4
    localparam int KEY_PEND_LSB  = 0;
    localparam int KEY_LEVEL_LSB = 4;

    // HEX register holds six display nibbles
    localparam int HEX_W = 24;

    typedef enum logic [2:0] {
        REG_SW    = 3'd0,
        REG_KEY   = 3'd1,
        REG_LED   = 3'd2,
        REG_HEX   = 3'd3,
        REG_TIMER = 3'd4,
        REG_NONE  = 3'd5
    } io_reg_e;

    // Decode a word index (addr[7:2]); byte lane bits are not part of the decode
    function automatic io_reg_e decode_word(input logic [5:0] widx);
        io_reg_e r;
        r = REG_NONE;
        if (widx == OFS_SW[7:2])         r = REG_SW;
        else if (widx == OFS_KEY[7:2])   r = REG_KEY;
        else if (widx == OFS_LED[7:2])   r = REG_LED;
        else if (widx == OFS_HEX[7:2])   r = REG_HEX;
        else if (widx == OFS_TIMER[7:2]) r = REG_TIMER;
        return r;
    endfunction

endpackage

// File: rtl/sc_io_bus_key_debounce.sv
// key_debounce: single-bit stable-count filter. dout follows din only after
// din has differed from dout for DB_CYCLES consecutive cycles; any return to
// the current dout value restarts the count. dout resets to 0 (released).
// The module is only needed when IO_KEY_DEBOUNCE_EN is defined, so it is only
// defined in that build and never appears as a stray top in the default one.
`ifdef IO_KEY_DEBOUNCE_EN
module key_debounce #(
    parameter int DB_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive differing cycles; accept the new level on the last one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din != dout) begin
            if (cnt == CNT_LAST) begin
                dout <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule
`endif

// File: rtl/sc_io_bus.sv
// sc_io_bus: data-side bus stage behind the single-cycle core. Routes each
// access either to data memory or to the memory-mapped I/O window (switches,
// keys with sticky press flags, LEDs, hex display value, millisecond timer).
// Reads are combinational; writes land on the rising clock edge.
// Optional build macro: IO_KEY_DEBOUNCE_EN adds a key_debounce filter per key.
module sc_io_bus
    import sc_io_bus_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
    parameter int          SW_W      = 10,
    parameter int          KEY_W     = 4,
    parameter int          LED_W     = 10,
    parameter int          TICK_DIV  = 50000,
    parameter int          DB_CYCLES = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              wmem,
    output logic [31:0]       rdata,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_we,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key_n,
    output logic [LED_W-1:0]  led,
    output logic [HEX_W-1:0]  hex_val
);

    localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    // Byte-lane bits take no part in the decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    logic    io_sel;
    io_reg_e reg_sel;
    logic    io_wr;

    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [KEY_W-1:0] key_meta;
    logic [KEY_W-1:0] key_sync;
    logic [KEY_W-1:0] raw_level;
    logic [KEY_W-1:0] level;
    logic [KEY_W-1:0] level_q;
    logic [KEY_W-1:0] key_rise;
    logic [KEY_W-1:0] key_clr;
    logic [KEY_W-1:0] pend;

    logic [PS_W-1:0]  prescaler;
    logic [31:0]      timer;
    logic [31:0]      rd_io;

    assign io_sel  = (addr[31:8] == IO_BASE[31:8]);
    assign reg_sel = io_sel ? decode_word(addr[7:2]) : REG_NONE;
    assign io_wr   = wmem & io_sel;
    assign dmem_we = wmem & ~io_sel;

    // Two-flop synchronisers; keys idle high (released) out of reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // Keys are active-low on the pins; level is 1 while pressed
    assign raw_level = ~key_sync;

`ifdef IO_KEY_DEBOUNCE_EN
    for (genvar i = 0; i < KEY_W; i++) begin : g_db
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .din   (raw_level[i]),
            .dout  (level[i])
        );
    end
`else
    localparam int UNUSED_DB_CYCLES = DB_CYCLES;
    assign level = raw_level;
`endif

    // A press is a rising edge of level; W1C from the core clears flags
    assign key_rise = level & ~level_q;
    assign key_clr  = (io_wr && reg_sel == REG_KEY) ? wdata[KEY_W-1:0] : '0;

    // Sticky press flags: a press in the same cycle as a clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            pend    <= '0;
        end else begin
            level_q <= level;
            pend    <= (pend & ~key_clr) | key_rise;
        end
    end

    // LED and HEX output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led     <= '0;
            hex_val <= '0;
        end else if (io_wr) begin
            if (reg_sel == REG_LED) led     <= wdata[LED_W-1:0];
            if (reg_sel == REG_HEX) hex_val <= wdata[HEX_W-1:0];
        end
    end

    // Prescaled timer; a core write reloads it and restarts the prescaler
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (io_wr && reg_sel == REG_TIMER) begin
            prescaler <= '0;
            timer     <= wdata;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            timer     <= timer + 32'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Zero-latency read mux; unmapped offsets inside the window read 0
    always_comb begin
        rd_io = '0;
        case (reg_sel)
            REG_SW:    rd_io[SW_W-1:0] = sw_sync;
            REG_KEY: begin
                rd_io[KEY_PEND_LSB  +: KEY_W] = pend;
                rd_io[KEY_LEVEL_LSB +: KEY_W] = level;
            end
            REG_LED:   rd_io[LED_W-1:0] = led;
            REG_HEX:   rd_io[HEX_W-1:0] = hex_val;
            REG_TIMER: rd_io            = timer;
            default:   rd_io            = '0;
        endcase
        rdata = io_sel ? rd_io : dmem_rdata;
    end

endmodule

// File: tb/tb_sc_io_bus.sv
// Self-checking bench for sc_io_bus (TICK_DIV=4, DB_CYCLES=8).
module tb_sc_io_bus;
    import sc_io_bus_pkg::*;

    localparam logic [31:0] IOB = 32'hFFFF_FF00;
`ifdef IO_KEY_DEBOUNCE_EN
    localparam int SET_EDGE = 3 + 8;
`else
    localparam int SET_EDGE = 3;
`endif

    logic        clock, reset;
    logic [31:0] addr, wdata, rdata, dmem_rdata;
    logic        wmem, dmem_we;
    logic [9:0]  sw;
    logic [3:0]  key_n;
    logic [9:0]  led;
    logic [23:0] hex_val;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    sc_io_bus #(
        .TICK_DIV  (4),
        .DB_CYCLES (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .wmem       (wmem),
        .rdata      (rdata),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .sw         (sw),
        .key_n      (key_n),
        .led        (led),
        .hex_val    (hex_val)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard: compare the oldest expected read against rdata
    task automatic sb_compare();
        logic [31:0] e;
        string nm;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check32(nm, rdata, e);
        end
    endtask

    // driver tasks (called just after a falling edge)
    task automatic read_reg(input logic [31:0] a, input string nm, input logic [31:0] e);
        addr = a;
        wmem = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
        sb_compare();
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wmem  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wmem  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [31:0] dm;
        logic [31:0] exp_rd;
        logic        exp_dwe;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h0000_0040, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[1]  = '{IOB | OFS_LED, 32'h1234_5678, 1'b1, 32'h1111_1111, 32'h0000_0000, 1'b0};
        vecs[2]  = '{IOB | OFS_LED, 32'h0,         1'b0, 32'h1111_1111, 32'h0000_0278, 1'b0};
        vecs[3]  = '{32'h0000_0040, 32'h0,         1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0};
        vecs[4]  = '{IOB | OFS_HEX, 32'hFFAB_CDEF, 1'b1, 32'h2222_2222, 32'h0000_0000, 1'b0};
        vecs[5]  = '{IOB | OFS_HEX, 32'h0,         1'b0, 32'h2222_2222, 32'h00AB_CDEF, 1'b0};
        vecs[6]  = '{IOB | 32'h3C,  32'h0,         1'b0, 32'h3333_3333, 32'h0000_0000, 1'b0};
        vecs[7]  = '{IOB | 32'h3C,  32'hFFFF_FFFF, 1'b1, 32'h3333_3333, 32'h0000_0000, 1'b0};
        vecs[8]  = '{IOB | OFS_LED, 32'h0,         1'b0, 32'h4444_4444, 32'h0000_0278, 1'b0};
        vecs[9]  = '{IOB | 32'h23,  32'h0,         1'b0, 32'h4444_4444, 32'h00AB_CDEF, 1'b0};
        vecs[10] = '{IOB | OFS_SW,  32'h0,         1'b0, 32'h5555_5555, 32'h0000_02A5, 1'b0};
        vecs[11] = '{32'hFFFF_FE10, 32'h0,         1'b0, 32'h6666_6666, 32'h6666_6666, 1'b0};
        vecs[12] = '{32'hFFFF_FE10, 32'h0000_0001, 1'b1, 32'h7777_7777, 32'h7777_7777, 1'b1};
    end

    initial begin
        reset      = 1'b1;
        addr       = 32'h0;
        wdata      = 32'h0;
        wmem       = 1'b0;
        dmem_rdata = 32'h0;
        sw         = 10'h2A5;
        key_n      = 4'hF;

        // reset state
        #1;
        check32("rst_led", {22'h0, led}, 32'h0);
        check32("rst_hex", {8'h0, hex_val}, 32'h0);
        check32("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
        read_reg(IOB | OFS_KEY, "rst_key", 32'h0);
        read_reg(IOB | OFS_TIMER, "rst_timer", 32'h0);

        // timer count from reset release
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_TIMER, "timer_12cyc", 32'd3);

        // table-driven routing and register vectors
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            addr       = vecs[i].a;
            wdata      = vecs[i].d;
            wmem       = vecs[i].we;
            dmem_rdata = vecs[i].dm;
            exp_q.push_back(vecs[i].exp_rd);
            name_q.push_back($sformatf("vec%0d_rdata", i));
            #1;
            sb_compare();
            check32($sformatf("vec%0d_dmem_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].exp_dwe});
        end
        @(negedge clock);
        wmem = 1'b0;
        check32("led_out", {22'h0, led}, 32'h278);
        check32("hex_out", {8'h0, hex_val}, 32'h00AB_CDEF);

        // key press sets pend, W1C clears, write 0 keeps
        key_n = 4'b1011;
        repeat (SET_EDGE + 1) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_KEY, "key_press", 32'h44);
        write_reg(IOB | OFS_KEY, 32'h0);
        read_reg(IOB | OFS_KEY, "key_w0_keeps", 32'h44);
        write_reg(IOB | OFS_KEY, 32'h4);
        read_reg(IOB | OFS_KEY, "key_w1c", 32'h40);
        key_n = 4'hF;
        repeat (SET_EDGE + 2) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_KEY, "key_release", 32'h0);

        // press lands in the same cycle as a W1C of that bit
        key_n = 4'b1011;
        repeat (SET_EDGE - 1) @(posedge clock);
        @(negedge clock);
        addr  = IOB | OFS_KEY;
        wdata = 32'h4;
        wmem  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wmem = 1'b0;
        read_reg(IOB | OFS_KEY, "key_set_wins", 32'h44);
        write_reg(IOB | OFS_KEY, 32'h4);
        key_n = 4'hF;
        repeat (SET_EDGE + 2) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_KEY, "key_idle", 32'h0);

        // timer wrap
        write_reg(IOB | OFS_TIMER, 32'hFFFF_FFFF);
        repeat (4) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_TIMER, "timer_wrap", 32'h0);

        // write on the tick cycle beats the tick and restarts the prescaler
        write_reg(IOB | OFS_TIMER, 32'h100);
        repeat (3) @(posedge clock);
        @(negedge clock);
        write_reg(IOB | OFS_TIMER, 32'h5555);
        read_reg(IOB | OFS_TIMER, "timer_wr_vs_tick", 32'h5555);
        repeat (3) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_TIMER, "timer_hold3", 32'h5555);
        @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_TIMER, "timer_tick_after", 32'h5556);

        // asynchronous reset mid-operation
        write_reg(IOB | OFS_LED, 32'h3FF);
        key_n = 4'h0;
        repeat (SET_EDGE + 1) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_KEY, "pre_rst_key", 32'hFF);
        write_reg(IOB | OFS_TIMER, 32'd7);
        read_reg(IOB | OFS_TIMER, "pre_rst_timer", 32'd7);
        reset = 1'b1;
        #1;
        check32("mid_rst_led", {22'h0, led}, 32'h0);
        check32("mid_rst_hex", {8'h0, hex_val}, 32'h0);
        read_reg(IOB | OFS_KEY, "mid_rst_key", 32'h0);
        read_reg(IOB | OFS_TIMER, "mid_rst_timer", 32'h0);
        key_n = 4'hF;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        read_reg(IOB | OFS_TIMER, "post_rst_timer0", 32'h0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        read_reg(IOB | OFS_TIMER, "post_rst_timer1", 32'h1);

`ifdef IO_KEY_DEBOUNCE_EN
        // bouncing key is rejected, a held press is accepted once
        for (int k = 0; k < 10; k++) begin
            key_n[0] = k[0];
            repeat (3) @(negedge clock);
        end
        read_reg(IOB | OFS_KEY, "db_bounce", 32'h0);
        key_n[0] = 1'b0;
        repeat (12) @(negedge clock);
        read_reg(IOB | OFS_KEY, "db_held", 32'h11);
        write_reg(IOB | OFS_KEY, 32'h1);
        read_reg(IOB | OFS_KEY, "db_clear", 32'h10);
        repeat (6) @(negedge clock);
        read_reg(IOB | OFS_KEY, "db_once", 32'h10);
`endif

        // final report
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
